// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - word-wide register access port of the interrupt controller
interface irq_ctrl_if;
   logic        CfgCS;
   logic        CfgWE;
   logic [1:0]  CfgAddr;
   logic [31:0] CfgWrData;
   logic [31:0] CfgRdData;
   logic        CfgRdy;

   modport master (
      output CfgCS, CfgWE, CfgAddr, CfgWrData,
      input  CfgRdData, CfgRdy
   );

   modport slave (
      input  CfgCS, CfgWE, CfgAddr, CfgWrData,
      output CfgRdData, CfgRdy
   );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - synchronised edge/level interrupt controller with ack/EOI service FSM
module irq_ctrl #(
   parameter int IRQ_CH      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IRQ_CH-1:0] IrqSrc,
   input  logic              IntAck,
   irq_ctrl_if.slave         cfg,
   output logic [IRQ_CH-1:0] IRQ,
   output logic              InSvc,
   output logic [ID_W-1:0]   InSvcId
);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_SERVICE = 1'b1;

   localparam logic [1:0] A_PENDING = 2'd0;
   localparam logic [1:0] A_EDGE    = 2'd1;
   localparam logic [1:0] A_ENABLE  = 2'd2;
   localparam logic [1:0] A_STATUS  = 2'd3;

   logic [IRQ_CH-1:0] sync_q [SYNC_STAGES];
   logic [IRQ_CH-1:0] s_now;
   logic [IRQ_CH-1:0] h_prev;
   logic [IRQ_CH-1:0] pending;
   logic [IRQ_CH-1:0] edge_mode;
   logic [IRQ_CH-1:0] enable;
   logic [0:0]        state;

   logic [IRQ_CH-1:0] req;
   logic              any_req;
   logic [ID_W-1:0]   win_id;
   logic              take;
   logic [IRQ_CH-1:0] ack_clr;
   logic [IRQ_CH-1:0] w1c;
   logic [IRQ_CH-1:0] edge_chg;
   logic [IRQ_CH-1:0] pending_n;
   logic [IRQ_CH-1:0] wr_bits;
   logic              wr;
   logic              eoi;
   logic [31:0]       rd_mux;
   logic              unused_wdata;

   assign s_now        = sync_q[SYNC_STAGES-1];
   assign wr_bits      = cfg.CfgWrData[IRQ_CH-1:0];
   assign unused_wdata = ^cfg.CfgWrData[31:IRQ_CH];
   assign wr           = cfg.CfgCS & cfg.CfgWE;
   assign eoi          = wr && (cfg.CfgAddr == A_STATUS) && (state == ST_SERVICE);
   assign req          = pending & enable;
   assign any_req      = |req;
   assign take         = IntAck && any_req && (state == ST_IDLE);
   assign InSvc        = (state == ST_SERVICE);

   // Source synchroniser chain plus one-cycle history for rising-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         h_prev <= '0;
      end else begin
         sync_q[0] <= IrqSrc;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         h_prev <= s_now;
      end
   end

   // Lowest-index enabled pending channel wins arbitration
   always_comb begin
      win_id = '0;
      for (int i = IRQ_CH - 1; i >= 0; i--) begin
         if (req[i]) win_id = ID_W'(i);
      end
   end

   // Next pending: edge channels latch rises (set beats clear), level channels follow the source;
   // a mode change discards whatever was latched under the old mode
   always_comb begin
      ack_clr   = take ? (IRQ_CH'(1) << win_id) : '0;
      w1c       = (wr && (cfg.CfgAddr == A_PENDING)) ? wr_bits : '0;
      edge_chg  = (wr && (cfg.CfgAddr == A_EDGE)) ? (wr_bits ^ edge_mode) : '0;
      pending_n = (edge_mode & ((pending & ~w1c & ~ack_clr) | (s_now & ~h_prev)))
                | (~edge_mode & s_now);
      pending_n = pending_n & ~edge_chg;
   end

   // Register file, pending state and service FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         pending   <= '0;
         edge_mode <= '1;
         enable    <= '0;
         state     <= ST_IDLE;
         InSvcId   <= '0;
      end else begin
         pending <= pending_n;
         if (wr && (cfg.CfgAddr == A_EDGE))   edge_mode <= wr_bits;
         if (wr && (cfg.CfgAddr == A_ENABLE)) enable    <= wr_bits;
         case (state)
            ST_IDLE: begin
               if (take) begin
                  state   <= ST_SERVICE;
                  InSvcId <= win_id;
               end
            end
            default: begin
               if (eoi) state <= ST_IDLE;
            end
         endcase
      end
   end

   // Request vector to the CPU is masked while a channel is in service
   always_ff @(posedge clk) begin
      if (reset) IRQ <= '0;
      else       IRQ <= (state == ST_IDLE) ? req : '0;
   end

   // Read data selection; unused upper bits read as zero
   always_comb begin
      rd_mux = '0;
      case (cfg.CfgAddr)
         A_PENDING: rd_mux = {{(32-IRQ_CH){1'b0}}, pending};
         A_EDGE:    rd_mux = {{(32-IRQ_CH){1'b0}}, edge_mode};
         A_ENABLE:  rd_mux = {{(32-IRQ_CH){1'b0}}, enable};
         default:   rd_mux = {{(31-ID_W){1'b0}}, InSvc, InSvcId};
      endcase
   end

   // Every access completes one cycle later; read data only for reads, zero otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg.CfgRdy    <= 1'b0;
         cfg.CfgRdData <= '0;
      end else begin
         cfg.CfgRdy    <= cfg.CfgCS;
         cfg.CfgRdData <= (cfg.CfgCS && !cfg.CfgWE) ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] IrqSrc = '0;
   logic       IntAck = 1'b0;
   logic [7:0] IRQ;
   logic       InSvc;
   logic [2:0] InSvcId;
   int         checks = 0;
   int         failures = 0;
   logic [31:0] rd;
   logic        rdy;

   irq_ctrl_if cfg_bus ();

   irq_ctrl #(.IRQ_CH(8), .SYNC_STAGES(SYNC), .ID_W(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .IrqSrc  (IrqSrc),
      .IntAck  (IntAck),
      .cfg     (cfg_bus),
      .IRQ     (IRQ),
      .InSvc   (InSvc),
      .InSvcId (InSvcId)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_bus.CfgCS = 1'b1; cfg_bus.CfgWE = 1'b1; cfg_bus.CfgAddr = a; cfg_bus.CfgWrData = d;
      tick(1);
      cfg_bus.CfgCS = 1'b0; cfg_bus.CfgWE = 1'b0;
   endtask

   task automatic cfg_read(input logic [1:0] a, output logic [31:0] d, output logic r);
      cfg_bus.CfgCS = 1'b1; cfg_bus.CfgWE = 1'b0; cfg_bus.CfgAddr = a;
      tick(1);
      cfg_bus.CfgCS = 1'b0;
      d = cfg_bus.CfgRdData;
      r = cfg_bus.CfgRdy;
   endtask

   task automatic pulse_ack();
      IntAck = 1'b1;
      tick(1);
      IntAck = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      checks++; if (IRQ !== 8'h00) begin failures++; $display("FAIL rst_irq got=%h exp=00", IRQ); end
      checks++; if (InSvc !== 1'b0 || InSvcId !== 3'd0) begin failures++; $display("FAIL rst_svc got=%b/%0d exp=0/0", InSvc, InSvcId); end
      checks++; if (cfg_bus.CfgRdy !== 1'b0 || cfg_bus.CfgRdData !== 32'h0) begin failures++; $display("FAIL rst_cfg got=%b/%h exp=0/0", cfg_bus.CfgRdy, cfg_bus.CfgRdData); end
      cfg_read(2'd1, rd, rdy);
      checks++; if (rd !== 32'hFF || rdy !== 1'b1) begin failures++; $display("FAIL rst_edge got=%h/%b exp=000000ff/1", rd, rdy); end
      cfg_read(2'd2, rd, rdy);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_enable got=%h exp=0", rd); end
   endtask

   task automatic test_edge_basic();
      cfg_write(2'd2, 32'h01);
      IrqSrc = 8'h01;
      tick(1);
      IrqSrc = 8'h00;
      tick(SYNC);
      checks++; if (IRQ !== 8'h00) begin failures++; $display("FAIL edge_early got=%h exp=00", IRQ); end
      tick(1);
      checks++; if (IRQ !== 8'h01) begin failures++; $display("FAIL edge_latency got=%h exp=01", IRQ); end
      cfg_read(2'd0, rd, rdy);
      checks++; if (rd !== 32'h01 || rdy !== 1'b1) begin failures++; $display("FAIL edge_pending got=%h/%b exp=00000001/1", rd, rdy); end
      cfg_write(2'd0, 32'h01);
      tick(1);
      checks++; if (IRQ !== 8'h00) begin failures++; $display("FAIL edge_w1c got=%h exp=00", IRQ); end
   endtask

   task automatic test_priority_service();
      cfg_write(2'd2, 32'hFF);
      IrqSrc = 8'h24;
      tick(1);
      IrqSrc = 8'h00;
      tick(SYNC + 1);
      checks++; if (IRQ !== 8'h24) begin failures++; $display("FAIL prio_irq got=%h exp=24", IRQ); end
      pulse_ack();
      checks++; if (InSvc !== 1'b1 || InSvcId !== 3'd2) begin failures++; $display("FAIL prio_svc got=%b/%0d exp=1/2", InSvc, InSvcId); end
      tick(1);
      checks++; if (IRQ !== 8'h00) begin failures++; $display("FAIL prio_masked got=%h exp=00", IRQ); end
      cfg_read(2'd0, rd, rdy);
      checks++; if (rd !== 32'h20) begin failures++; $display("FAIL prio_pending got=%h exp=20", rd); end
      cfg_read(2'd3, rd, rdy);
      checks++; if (rd !== 32'h0A) begin failures++; $display("FAIL prio_status got=%h exp=0a", rd); end
      cfg_write(2'd3, 32'hDEAD);
      checks++; if (InSvc !== 1'b0) begin failures++; $display("FAIL prio_eoi got=%b exp=0", InSvc); end
      tick(1);
      checks++; if (IRQ !== 8'h20) begin failures++; $display("FAIL prio_next got=%h exp=20", IRQ); end
      pulse_ack();
      checks++; if (InSvcId !== 3'd5) begin failures++; $display("FAIL prio_id5 got=%0d exp=5", InSvcId); end
      cfg_write(2'd3, 32'h0);
      tick(1);
      checks++; if (IRQ !== 8'h00) begin failures++; $display("FAIL prio_drained got=%h exp=00", IRQ); end
   endtask

   task automatic test_level();
      cfg_write(2'd1, 32'hFE);
      IrqSrc = 8'h01;
      tick(SYNC + 2);
      checks++; if (IRQ !== 8'h01) begin failures++; $display("FAIL lvl_irq got=%h exp=01", IRQ); end
      cfg_write(2'd0, 32'h01);
      cfg_read(2'd0, rd, rdy);
      checks++; if (rd !== 32'h01) begin failures++; $display("FAIL lvl_w1c got=%h exp=01", rd); end
      IrqSrc = 8'h00;
      tick(SYNC + 1);
      checks++; if (IRQ !== 8'h01) begin failures++; $display("FAIL lvl_hold got=%h exp=01", IRQ); end
      tick(1);
      checks++; if (IRQ !== 8'h00) begin failures++; $display("FAIL lvl_drop got=%h exp=00", IRQ); end
      cfg_write(2'd1, 32'hFF);
   endtask

   task automatic test_set_wins_enable();
      IrqSrc = 8'h08;
      tick(1);
      IrqSrc = 8'h00;
      tick(SYNC + 1);
      checks++; if (IRQ !== 8'h08) begin failures++; $display("FAIL sw_first got=%h exp=08", IRQ); end
      IrqSrc = 8'h08;
      tick(1);
      IrqSrc = 8'h00;
      tick(1);
      cfg_write(2'd0, 32'h08);
      cfg_read(2'd0, rd, rdy);
      checks++; if (rd !== 32'h08) begin failures++; $display("FAIL sw_set_wins got=%h exp=08", rd); end
      cfg_write(2'd2, 32'hF7);
      checks++; if (IRQ !== 8'h08) begin failures++; $display("FAIL en_same_cycle got=%h exp=08", IRQ); end
      tick(1);
      checks++; if (IRQ !== 8'h00) begin failures++; $display("FAIL en_drop got=%h exp=00", IRQ); end
      cfg_read(2'd0, rd, rdy);
      checks++; if (rd !== 32'h08) begin failures++; $display("FAIL en_retained got=%h exp=08", rd); end
      cfg_write(2'd2, 32'hFF);
      cfg_write(2'd0, 32'h08);
      tick(2);
      checks++; if (IRQ !== 8'h00) begin failures++; $display("FAIL sw_cleared got=%h exp=00", IRQ); end
   endtask

   task automatic test_ack_idle();
      cfg_write(2'd2, 32'hFD);
      IrqSrc = 8'h02;
      tick(1);
      IrqSrc = 8'h00;
      tick(SYNC + 1);
      pulse_ack();
      checks++; if (InSvc !== 1'b0) begin failures++; $display("FAIL ack_idle got=%b exp=0", InSvc); end
      cfg_read(2'd0, rd, rdy);
      checks++; if (rd !== 32'h02) begin failures++; $display("FAIL ack_pending got=%h exp=02", rd); end
      cfg_write(2'd3, 32'h1);
      checks++; if (InSvc !== 1'b0 || IRQ !== 8'h00) begin failures++; $display("FAIL eoi_idle got=%b/%h exp=0/00", InSvc, IRQ); end
   endtask

   task automatic test_back_to_back();
      cfg_bus.CfgCS = 1'b1; cfg_bus.CfgWE = 1'b1; cfg_bus.CfgAddr = 2'd2; cfg_bus.CfgWrData = 32'hFFFFFF5A;
      tick(1);
      checks++; if (cfg_bus.CfgRdy !== 1'b1 || cfg_bus.CfgRdData !== 32'h0) begin failures++; $display("FAIL b2b_wr got=%b/%h exp=1/0", cfg_bus.CfgRdy, cfg_bus.CfgRdData); end
      cfg_bus.CfgWE = 1'b0; cfg_bus.CfgAddr = 2'd1;
      tick(1);
      checks++; if (cfg_bus.CfgRdy !== 1'b1 || cfg_bus.CfgRdData !== 32'hFF) begin failures++; $display("FAIL b2b_rd1 got=%b/%h exp=1/ff", cfg_bus.CfgRdy, cfg_bus.CfgRdData); end
      cfg_bus.CfgAddr = 2'd2;
      tick(1);
      checks++; if (cfg_bus.CfgRdy !== 1'b1 || cfg_bus.CfgRdData !== 32'h5A) begin failures++; $display("FAIL b2b_rd2 got=%b/%h exp=1/5a", cfg_bus.CfgRdy, cfg_bus.CfgRdData); end
      cfg_bus.CfgCS = 1'b0;
      tick(1);
      checks++; if (cfg_bus.CfgRdy !== 1'b0 || cfg_bus.CfgRdData !== 32'h0) begin failures++; $display("FAIL b2b_idle got=%b/%h exp=0/0", cfg_bus.CfgRdy, cfg_bus.CfgRdData); end
   endtask

   task automatic test_reset_in_service();
      cfg_write(2'd2, 32'hFF);
      tick(1);
      checks++; if (IRQ !== 8'h02) begin failures++; $display("FAIL rs_irq got=%h exp=02", IRQ); end
      pulse_ack();
      checks++; if (InSvc !== 1'b1 || InSvcId !== 3'd1) begin failures++; $display("FAIL rs_svc got=%b/%0d exp=1/1", InSvc, InSvcId); end
      IrqSrc = 8'h40;
      tick(1);
      IrqSrc = 8'h00;
      tick(SYNC + 1);
      reset = 1'b1;
      cfg_bus.CfgCS = 1'b1; cfg_bus.CfgWE = 1'b0; cfg_bus.CfgAddr = 2'd0;
      tick(1);
      reset = 1'b0;
      cfg_bus.CfgCS = 1'b0;
      checks++; if (IRQ !== 8'h00 || InSvc !== 1'b0 || InSvcId !== 3'd0) begin failures++; $display("FAIL rs_outputs got=%h/%b/%0d exp=00/0/0", IRQ, InSvc, InSvcId); end
      checks++; if (cfg_bus.CfgRdy !== 1'b0 || cfg_bus.CfgRdData !== 32'h0) begin failures++; $display("FAIL rs_cfg got=%b/%h exp=0/0", cfg_bus.CfgRdy, cfg_bus.CfgRdData); end
      cfg_read(2'd0, rd, rdy);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rs_pending got=%h exp=0", rd); end
      cfg_read(2'd1, rd, rdy);
      checks++; if (rd !== 32'hFF) begin failures++; $display("FAIL rs_edge got=%h exp=ff", rd); end
      cfg_read(2'd2, rd, rdy);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rs_enable got=%h exp=0", rd); end
      cfg_read(2'd3, rd, rdy);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rs_status got=%h exp=0", rd); end
   endtask

   initial begin
      cfg_bus.CfgCS = 1'b0;
      cfg_bus.CfgWE = 1'b0;
      cfg_bus.CfgAddr = 2'd0;
      cfg_bus.CfgWrData = 32'h0;
      #1;
      test_reset();
      test_edge_basic();
      test_priority_service();
      test_level();
      test_set_wins_enable();
      test_ack_idle();
      test_back_to_back();
      test_reset_in_service();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
